// File: rtl/sdram_init_refresh_if.sv
// SDRAM command pins plus the refresh request/grant handshake.
// master: the init/refresh controller; slave: the pins/arbiter side.
interface sdram_init_refresh_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned BA_W   = 2
);
    logic              sdr_ck;
    logic              sdr_cke;
    logic              sdr_csn;
    logic              sdr_rasn;
    logic              sdr_casn;
    logic              sdr_wen;
    logic [ADDR_W-1:0] sdr_addr;
    logic [BA_W-1:0]   sdr_ba;
    logic              init_done;
    logic              ref_req;
    logic              ref_ack;
    logic              ref_done;

    modport master (
        output sdr_ck, sdr_cke, sdr_csn, sdr_rasn, sdr_casn, sdr_wen, sdr_addr, sdr_ba,
        output init_done, ref_req, ref_done,
        input  ref_ack
    );

    modport slave (
        input  sdr_ck, sdr_cke, sdr_csn, sdr_rasn, sdr_casn, sdr_wen, sdr_addr, sdr_ba,
        input  init_done, ref_req, ref_done,
        output ref_ack
    );
endinterface

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer (wait, precharge-all, N auto-refreshes, load-mode) with optional
// periodic auto-refresh, compiled in when SDRAM_AUTO_REFRESH_EN is defined.
module sdram_init_refresh #(
    parameter int unsigned       CLK_MHZ      = 100,
    parameter int unsigned       INIT_US      = 200,
    parameter int unsigned       tRP          = 3,
    parameter int unsigned       tRFC         = 7,
    parameter int unsigned       tMRD         = 2,
    parameter int unsigned       ADDR_W       = 11,
    parameter int unsigned       BA_W         = 2,
    parameter int unsigned       INIT_REF_N   = 2,
    parameter logic [ADDR_W-1:0] MODE_REG     = ADDR_W'(11'h032),
    parameter int unsigned       REF_INTERVAL = 780
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_init_refresh_if.master  bus
);

    localparam int unsigned InitCyc = INIT_US * CLK_MHZ;
    localparam int unsigned Gap1    = (InitCyc > tRP) ? InitCyc : tRP;
    localparam int unsigned Gap2    = (Gap1 > tRFC) ? Gap1 : tRFC;
    localparam int unsigned MaxGap  = (Gap2 > tMRD) ? Gap2 : tMRD;
    localparam int unsigned CntW    = $clog2(MaxGap + 1);
    localparam int unsigned RefNW   = $clog2(INIT_REF_N + 1);

    localparam logic [CntW-1:0]  InitCycC = CntW'(InitCyc);
    localparam logic [CntW-1:0]  TrpC     = CntW'(tRP);
    localparam logic [CntW-1:0]  TrfcC    = CntW'(tRFC);
    localparam logic [CntW-1:0]  TmrdC    = CntW'(tMRD);
    localparam logic [RefNW-1:0] RefNC    = RefNW'(INIT_REF_N);

    // {csn, rasn, casn, wen}
    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;
    localparam logic [3:0] CmdMrs = 4'b0000;

`ifdef SDRAM_AUTO_REFRESH_EN
    typedef enum logic [2:0] {StWait, StPre, StRef, StMrs, StIdle, StAref} state_e;
`else
    typedef enum logic [2:0] {StWait, StPre, StRef, StMrs, StIdle} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RefNW-1:0]  refn_q, refn_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic              cke_q, cke_d;
    logic              init_done_q, init_done_d;
    logic              init_rise;

    // cnt_q counts cycles since the last command; a command fires when it reaches the gap.
    assign init_rise = (state_q == StMrs) && (cnt_q == TmrdC);

`ifdef SDRAM_AUTO_REFRESH_EN
    localparam int unsigned     RtW = $clog2(REF_INTERVAL + 1);
    localparam logic [RtW-1:0]  RiC = RtW'(REF_INTERVAL);

    logic [RtW-1:0] rtmr_q, rtmr_d;
    logic [2:0]     pend_q, pend_d;
    logic           ref_req_q, ref_req_d;
    logic           ref_done_q, ref_done_d;
    logic           ack_go, expire;

    assign ack_go = (state_q == StIdle) && ref_req_q && bus.ref_ack;
    assign expire = (rtmr_q == RiC);

    // rtmr_q == 0 means the timer has not been started by init completion yet.
    always_comb begin
        rtmr_d = rtmr_q;
        pend_d = pend_q;
        if (init_rise) begin
            rtmr_d = RtW'(1);
        end else if (rtmr_q != '0) begin
            rtmr_d = expire ? RtW'(1) : rtmr_q + RtW'(1);
        end
        if (expire && !ack_go) begin
            if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
        end else if (ack_go && !expire) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rtmr_q     <= '0;
            pend_q     <= '0;
            ref_req_q  <= 1'b0;
            ref_done_q <= 1'b0;
        end else begin
            rtmr_q     <= rtmr_d;
            pend_q     <= pend_d;
            ref_req_q  <= ref_req_d;
            ref_done_q <= ref_done_d;
        end
    end

    assign bus.ref_req  = ref_req_q;
    assign bus.ref_done = ref_done_q;
`else
    logic unused_ref_ack;
    assign unused_ref_ack = bus.ref_ack;
    assign bus.ref_req    = 1'b0;
    assign bus.ref_done   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StWait;
            cnt_q       <= '0;
            refn_q      <= '0;
            cmd_q       <= CmdNop;
            addr_q      <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            refn_q      <= refn_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            cke_q       <= cke_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        refn_d  = refn_q;
        unique case (state_q)
            StWait: if (cnt_q == InitCycC) begin
                state_d = StPre;
                cnt_d   = CntW'(1);
            end
            StPre: if (cnt_q == TrpC) begin
                state_d = StRef;
                cnt_d   = CntW'(1);
                refn_d  = RefNW'(1);
            end
            StRef: if (cnt_q == TrfcC) begin
                cnt_d = CntW'(1);
                if (refn_q == RefNC) state_d = StMrs;
                else                 refn_d  = refn_q + RefNW'(1);
            end
            StMrs: if (cnt_q == TmrdC) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            StIdle: begin
                cnt_d = '0;
`ifdef SDRAM_AUTO_REFRESH_EN
                if (ack_go) begin
                    state_d = StAref;
                    cnt_d   = CntW'(1);
                end
`endif
            end
`ifdef SDRAM_AUTO_REFRESH_EN
            StAref: if (cnt_q == TrfcC) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = StWait;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (values registered at the same edge the state advances)
    always_comb begin
        cmd_d       = CmdNop;
        addr_d      = '0;
        ba_d        = '0;
        cke_d       = 1'b1;
        init_done_d = init_done_q | init_rise;
        unique case (state_q)
            StWait: if (cnt_q == InitCycC) begin
                cmd_d      = CmdPre;
                addr_d[10] = 1'b1;
            end
            StPre: if (cnt_q == TrpC) cmd_d = CmdRef;
            StRef: if (cnt_q == TrfcC) begin
                if (refn_q == RefNC) begin
                    cmd_d  = CmdMrs;
                    addr_d = MODE_REG;
                end else begin
                    cmd_d = CmdRef;
                end
            end
`ifdef SDRAM_AUTO_REFRESH_EN
            StIdle: if (ack_go) cmd_d = CmdRef;
`endif
            default: ;
        endcase
`ifdef SDRAM_AUTO_REFRESH_EN
        ref_req_d  = (pend_d != 3'd0) && (state_d == StIdle);
        ref_done_d = (state_q == StAref) && (cnt_q == TrfcC);
`endif
    end

    assign bus.sdr_ck    = ~clk;
    assign bus.sdr_cke   = cke_q;
    assign {bus.sdr_csn, bus.sdr_rasn, bus.sdr_casn, bus.sdr_wen} = cmd_q;
    assign bus.sdr_addr  = addr_q;
    assign bus.sdr_ba    = ba_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Self-checking bench for sdram_init_refresh: randomized ref_ack against a cycle-indexed
// reference model built from absolute command times, expiry arithmetic and a pending count.
module tb_sdram_init_refresh;

    localparam int T_RP = 3, T_RFC = 7, T_MRD = 2, INIT_REF_N = 2, RI = 780;
    localparam int INIT_CYC = 100 * 200;
    localparam int PRE_AT   = INIT_CYC;
    localparam int MRS_AT   = PRE_AT + T_RP + INIT_REF_N * T_RFC;
    localparam int DONE_AT  = MRS_AT + T_MRD;
    localparam logic [10:0] MODE = 11'h032;
`ifdef SDRAM_AUTO_REFRESH_EN
    localparam bit REN = 1'b1;
`else
    localparam bit REN = 1'b0;
`endif
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef struct packed {
        logic        cke;
        logic [3:0]  cmd;
        logic [10:0] addr;
        logic [1:0]  ba;
        logic        init_done;
        logic        ref_req;
        logic        ref_done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_init_refresh_if #(.ADDR_W(11), .BA_W(2)) bus ();

    sdram_init_refresh #(
        .CLK_MHZ(100), .INIT_US(200), .tRP(T_RP), .tRFC(T_RFC), .tMRD(T_MRD), .ADDR_W(11),
        .BA_W(2), .INIT_REF_N(INIT_REF_N), .MODE_REG(MODE), .REF_INTERVAL(RI)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc = -1;
    int m_pend, m_done_at, m_issued, d_issued;
    bit m_req, m_busy;

    function automatic obs_t sample();
        return obs_t'({bus.sdr_cke, bus.sdr_csn, bus.sdr_rasn, bus.sdr_casn, bus.sdr_wen,
                       bus.sdr_addr, bus.sdr_ba, bus.init_done, bus.ref_req, bus.ref_done});
    endfunction

    function automatic obs_t reset_val();
        obs_t v;
        v = '0;
        v.cmd = CMD_NOP;
        return v;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_req = 0; m_busy = 0; m_done_at = 0; m_issued = 0; d_issued = 0;
    endtask

    // Expected outputs after edge number cyc, given the ack sampled at that edge.
    task automatic model_edge(input logic ack, output obs_t e);
        bit issue, expire;
        e = '0;
        e.cke = 1'b1;
        e.cmd = CMD_NOP;
        if (cyc == PRE_AT) begin e.cmd = CMD_PRE; e.addr[10] = 1'b1; end
        for (int i = 0; i < INIT_REF_N; i++)
            if (cyc == PRE_AT + T_RP + i * T_RFC) e.cmd = CMD_REF;
        if (cyc == MRS_AT) begin e.cmd = CMD_MRS; e.addr = MODE; end
        e.init_done = (cyc >= DONE_AT);
        issue  = REN && ack && m_req;
        expire = REN && (cyc > DONE_AT) && ((cyc - DONE_AT) % RI == 0);
        if (expire && !issue) m_pend = (m_pend < 7) ? m_pend + 1 : 7;
        else if (issue && !expire) m_pend = m_pend - 1;
        if (issue) begin
            e.cmd = CMD_REF; m_busy = 1; m_done_at = cyc + T_RFC; m_issued++;
        end
        e.ref_done = m_busy && (cyc == m_done_at);
        if (e.ref_done) m_busy = 0;
        m_req = REN && (cyc >= DONE_AT) && (m_pend > 0) && !m_busy;
        e.ref_req = m_req;
    endtask

    task automatic tick(input logic ack, output obs_t o, output obs_t e);
        bus.ref_ack = ack;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(ack, e);
        o = sample();
        if (o.cmd == CMD_REF && o.init_done) d_issued++;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ref_ack = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            o = sample();
            checks++;
            if (o !== reset_val()) $display("FAIL reset_state: got %h expected %h", o, reset_val());
            else passed++;
        end
        checks++;
        if (bus.sdr_ck !== ~clk) $display("FAIL sdr_ck: got %b expected %b", bus.sdr_ck, ~clk);
        else passed++;
        model_reset();
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic test_init();
        obs_t o, e;
        int bad = 0;
        for (int k = 0; k <= DONE_AT + 1; k++) begin
            tick(1'($urandom_range(0, 1)), o, e);
            if (o !== e) begin
                if (bad == 0) $display("FAIL init_first_bad: cycle %0d got %h expected %h", cyc, o, e);
                bad++;
            end
            case (cyc)
                0: begin checks++;
                    if (o.cke !== 1'b1) $display("FAIL cke_cycle0: got %b expected 1", o.cke);
                    else passed++; end
                19999: begin checks++;
                    if (o.cmd !== CMD_NOP) $display("FAIL nop_19999: got %b expected %b", o.cmd, CMD_NOP);
                    else passed++; end
                20000: begin checks++;
                    if ({o.cmd, o.addr, o.ba} !== {CMD_PRE, 11'h400, 2'b00})
                        $display("FAIL pre_20000: got %b/%h expected 0010/400", o.cmd, o.addr);
                    else passed++; end
                20003, 20010: begin checks++;
                    if (o.cmd !== CMD_REF) $display("FAIL init_ref_%0d: got %b expected 0001", cyc, o.cmd);
                    else passed++; end
                20017: begin checks++;
                    if ({o.cmd, o.addr, o.ba} !== {CMD_MRS, 11'h032, 2'b00})
                        $display("FAIL mrs_20017: got %b/%h expected 0000/032", o.cmd, o.addr);
                    else passed++; end
                20018: begin checks++;
                    if (o.init_done !== 1'b0) $display("FAIL done_early: got %b expected 0", o.init_done);
                    else passed++; end
                20019: begin checks++;
                    if (o.init_done !== 1'b1) $display("FAIL done_20019: got %b expected 1", o.init_done);
                    else passed++; end
                default: ;
            endcase
        end
        checks++;
        if (bad != 0) $display("FAIL init_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_refresh_hold();
        obs_t o, e;
        int bad = 0, refs = 0;
        while (cyc < 20809) begin
            tick(1'b1, o, e);
            if (o !== e) bad++;
            if (cyc >= 20800 && o.cmd == CMD_REF) refs++;
            case (cyc)
                20798, 20799: begin checks++;
                    if (o.ref_req !== (cyc == 20799 && REN))
                        $display("FAIL ref_req_%0d: got %b expected %b", cyc, o.ref_req, (cyc == 20799 && REN));
                    else passed++; end
                20800: begin checks++;
                    if ({o.cmd, o.ref_req} !== {(REN ? CMD_REF : CMD_NOP), 1'b0})
                        $display("FAIL aref_20800: got %b/%b expected %b/0", o.cmd, o.ref_req,
                                 (REN ? CMD_REF : CMD_NOP));
                    else passed++; end
                20806, 20807, 20808: begin checks++;
                    if (o.ref_done !== (cyc == 20807 && REN))
                        $display("FAIL ref_done_%0d: got %b expected %b", cyc, o.ref_done, (cyc == 20807 && REN));
                    else passed++; end
                default: ;
            endcase
        end
        checks++;
        if (refs != (REN ? 1 : 0)) $display("FAIL ack_during_aref: got %0d refreshes expected %0d", refs, REN ? 1 : 0);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL hold_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_saturate();
        obs_t o, e;
        int bad = 0, cnt = 0, last = -1, sp_bad = 0;
        for (int k = 0; k < 8 * RI; k++) begin
            tick(1'b0, o, e);
            if (o !== e) bad++;
        end
        for (int k = 0; k < 7 * 8 + 16; k++) begin
            tick(1'b1, o, e);
            if (o !== e) bad++;
            if (o.cmd == CMD_REF) begin
                cnt++;
                if (last >= 0 && cyc - last != 8) sp_bad++;
                last = cyc;
            end
        end
        checks++;
        if (cnt != (REN ? 7 : 0)) $display("FAIL sat_count: got %0d expected %0d", cnt, REN ? 7 : 0);
        else passed++;
        checks++;
        if (sp_bad != 0) $display("FAIL sat_spacing: got %0d bad gaps expected 0", sp_bad);
        else passed++;
        checks++;
        if (o.ref_req !== 1'b0) $display("FAIL sat_req_after: got %b expected 0", o.ref_req);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL sat_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_ack_ignored();
        obs_t o, e;
        int bad = 0, stray = 0, refs = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'(k % 2), o, e);
            if (o !== e) bad++;
            if (o.cmd != CMD_NOP) stray++;
        end
        checks++;
        if (stray != 0) $display("FAIL ack_ignored_cmd: got %0d commands expected 0", stray);
        else passed++;
        for (int k = 0; k < RI; k++) begin
            tick(1'b0, o, e);
            if (o !== e) bad++;
        end
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, o, e);
            if (o !== e) bad++;
            if (o.cmd == CMD_REF) refs++;
        end
        checks++;
        if (refs != (REN ? 1 : 0)) $display("FAIL ack_ignored_pend: got %0d refreshes expected %0d", refs, REN ? 1 : 0);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL ignored_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_random_ack();
        obs_t o, e;
        int bad = 0;
        for (int k = 0; k < 4 * RI; k++) begin
            tick($urandom_range(0, 3) == 0, o, e);
            if (o !== e) bad++;
        end
        checks++;
        if (d_issued != m_issued) $display("FAIL random_refs: got %0d expected %0d", d_issued, m_issued);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL random_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_mid_reset();
        obs_t o, e;
        int bad = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        cyc = -1;
        while (cyc < 20004) begin
            tick(1'($urandom_range(0, 1)), o, e);
            if (o !== e) bad++;
            if (cyc == 20003) begin
                checks++;
                if (o.cmd !== CMD_REF) $display("FAIL mid_ref_20003: got %b expected 0001", o.cmd);
                else passed++;
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        o = sample();
        checks++;
        if (o !== reset_val()) $display("FAIL mid_reset_state: got %h expected %h", o, reset_val());
        else passed++;
        model_reset();
        rst_n = 1'b1;
        cyc = -1;
        while (cyc < DONE_AT) begin
            tick(1'($urandom_range(0, 1)), o, e);
            if (o !== e) bad++;
            if (cyc == 20000) begin
                checks++;
                if ({o.cmd, o.addr} !== {CMD_PRE, 11'h400})
                    $display("FAIL mid_pre_20000: got %b/%h expected 0010/400", o.cmd, o.addr);
                else passed++;
            end
        end
        checks++;
        if (o.init_done !== 1'b1) $display("FAIL mid_done: got %b expected 1", o.init_done);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL mid_stream: got %0d bad cycles expected 0", bad);
        else passed++;
    endtask

    initial begin
        bus.ref_ack = 1'b0;
        model_reset();
        test_reset();
        test_init();
        test_refresh_hold();
        test_saturate();
        test_ack_ignored();
        test_random_ack();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sdram_init_refresh.md
SDRAM_INIT_REFRESH -- requirements
Module: sdram_init_refresh

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, clock frequency in MHz.
REQ-002 SHALL have parameter INIT_US, default 200, power-up wait in microseconds.
REQ-003 SHALL have parameters tRP, tRFC, tMRD, defaults 3, 7, 2, command spacing in clocks (each >= 1).
REQ-004 SHALL have parameter ADDR_W, default 11, SDRAM address width (>= 11).
REQ-005 SHALL have parameter BA_W, default 2, bank-address width.
REQ-006 SHALL have parameter INIT_REF_N, default 2, auto-refreshes in init (>= 1).
REQ-007 SHALL have parameter MODE_REG, default 'h032 zero-extended to ADDR_W, mode value (CL3, BL4, sequential).
REQ-008 SHALL have parameter REF_INTERVAL, default 780, clocks between refresh requests.
REQ-009 clk  in  1  sole clock; all logic on rising edge.
REQ-010 rst_n  in  1  synchronous, active-low reset.
REQ-011 sdr_ck  out  1  SDRAM clock, equal to ~clk.
REQ-012 sdr_cke, sdr_csn, sdr_rasn, sdr_casn, sdr_wen  out  1 each  SDRAM control pins, registered.
REQ-013 sdr_addr  out  ADDR_W; sdr_ba  out  BA_W; registered.
REQ-014 init_done  out  1  high from init completion until reset.
REQ-015 ref_req  out  1  periodic refresh pending; ref_ack  in  1  bus granted; ref_done  out  1  one-cycle refresh-complete pulse.

Function
REQ-016 Commands {csn,rasn,casn,wen}: NOP 0111, PRECHARGE-ALL 0010 with addr[10]=1, AUTO-REFRESH 0001, LOAD-MODE 0000 with addr=MODE_REG, ba=0; all other cycles NOP with addr=0, ba=0.
REQ-017 Each command SHALL last exactly one cycle; the next command issues exactly tX cycles later (tRP after precharge, tRFC after refresh, tMRD after load-mode).
REQ-018 States: WAIT -> PRE -> REF (INIT_REF_N times) -> MRS -> IDLE; with refresh enabled, IDLE -> AREF -> IDLE.
REQ-019 Cycle 0 = first edge sampling rst_n high; sdr_cke SHALL be 1 from cycle 0; WAIT lasts INIT_US*CLK_MHZ cycles; PRECHARGE issues at cycle INIT_US*CLK_MHZ.
REQ-020 init_done SHALL rise tMRD cycles after LOAD-MODE issues and remain 1.
REQ-021 Refresh timer SHALL start at init_done rise, count REF_INTERVAL cycles, increment a 3-bit saturating pending count at each expiry and reload.
REQ-022 ref_req SHALL be 1 while pending count > 0 and the block is in IDLE.
REQ-023 ref_ack sampled high with ref_req high SHALL issue AUTO-REFRESH the next cycle and decrement pending; ref_req drops in that command cycle.
REQ-024 ref_done SHALL pulse one cycle tRFC cycles after AUTO-REFRESH; IDLE then re-evaluates pending.
REQ-025 ref_ack while ref_req is low, or during AREF, SHALL be ignored.
REQ-026 Simultaneous timer expiry and ack SHALL net pending unchanged; pending saturates at 7.

Reset
REQ-027 rst_n low at an edge SHALL set: sdr_cke=0, command NOP, sdr_addr=0, sdr_ba=0, init_done=0, ref_req=0, ref_done=0, pending=0, timers=0, state WAIT.
REQ-028 Reset mid-sequence (any state) SHALL abort and restart full initialisation from cycle 0.

Configuration
REQ-029 Macro SDRAM_AUTO_REFRESH_EN defined: periodic refresh logic per REQ-021..026 compiled in.
REQ-030 Macro undefined: timer, pending count and AREF state absent; ref_req and ref_done tied 0; ref_ack unused; IDLE issues NOP forever.

Verification (defaults, SDRAM_AUTO_REFRESH_EN defined)
REQ-031 Release reset -> NOP cycles 0..19999; PRE at 20000; REF at 20003 and 20010; LOAD-MODE addr=0x032 at 20017; init_done=1 at 20019.
REQ-032 Hold ref_ack=1 after init -> ref_req at 20799; AUTO-REFRESH at 20800; ref_done pulse at 20807.
REQ-033 Hold ref_ack=0 for 8 intervals -> pending saturates at 7; then ref_ack=1 -> 7 refreshes spaced 8 cycles apart (1 arbitration cycle + tRFC), ref_req low afterwards.
REQ-034 Assert rst_n=0 one cycle at cycle 20005 -> outputs reset-valued next edge; PRECHARGE reissues 20000 cycles after release.
REQ-035 ref_ack pulsed with ref_req=0 -> no command, pending unchanged.
REQ-036 Macro undefined -> identical init timing; ref_req stays 0 for 10000 cycles after init_done.
